// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline register with a skid buffer. The outputs come straight from the main entry's flops.
// in_ready_o comes only from the skid entry's valid flag, so out_ready_i never reaches the upstream side.
module pipe_stage_skid #(
    parameter int DATA_W = 134,
    parameter int CTRL_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_reg;
    logic                main_valid_reg;
    logic [CTRL_W-1:0]   main_ctrl_reg;
    logic [DATA_W-1:0]   main_data_reg;
    logic                skid_valid_reg;
    logic [CTRL_W-1:0]   skid_ctrl_reg;
    logic [DATA_W-1:0]   skid_data_reg;
    logic [1:0]          occupancy_reg;
    logic [CNT_W-1:0]    stall_cnt_reg;

    logic accept;
    logic transfer;

    assign accept   = in_valid_i && !skid_valid_reg && !flush_i;
    assign transfer = main_valid_reg && out_ready_i;

    assign in_ready_o  = !skid_valid_reg;
    assign out_valid_o = main_valid_reg;
    assign out_ctrl_o  = main_ctrl_reg;
    assign out_data_o  = main_data_reg;
    assign occupancy_o = occupancy_reg;
    assign stall_cnt_o = stall_cnt_reg;

    // Control registers are cleared whenever their entry goes invalid, so a bubble carries all-zero control.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg      <= ST_EMPTY;
            main_valid_reg <= 1'b0;
            main_ctrl_reg  <= '0;
            main_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_ctrl_reg  <= '0;
            skid_data_reg  <= '0;
            occupancy_reg  <= 2'd0;
            stall_cnt_reg  <= '0;
        end else begin
            if (main_valid_reg && !out_ready_i && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);

            if (flush_i) begin
                state_reg      <= ST_EMPTY;
                main_valid_reg <= 1'b0;
                main_ctrl_reg  <= '0;
                skid_valid_reg <= 1'b0;
                skid_ctrl_reg  <= '0;
                occupancy_reg  <= 2'd0;
            end else begin
                case (state_reg)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_valid_reg <= 1'b1;
                            main_ctrl_reg  <= in_ctrl_i;
                            main_data_reg  <= in_data_i;
                            state_reg      <= ST_ONE;
                            occupancy_reg  <= 2'd1;
                        end
                    end
                    ST_ONE: begin
                        if (accept && transfer) begin
                            main_ctrl_reg <= in_ctrl_i;
                            main_data_reg <= in_data_i;
                        end else if (accept) begin
                            skid_valid_reg <= 1'b1;
                            skid_ctrl_reg  <= in_ctrl_i;
                            skid_data_reg  <= in_data_i;
                            state_reg      <= ST_FULL;
                            occupancy_reg  <= 2'd2;
                        end else if (transfer) begin
                            main_valid_reg <= 1'b0;
                            main_ctrl_reg  <= '0;
                            state_reg      <= ST_EMPTY;
                            occupancy_reg  <= 2'd0;
                        end
                    end
                    ST_FULL: begin
                        if (transfer) begin
                            main_ctrl_reg  <= skid_ctrl_reg;
                            main_data_reg  <= skid_data_reg;
                            skid_valid_reg <= 1'b0;
                            skid_ctrl_reg  <= '0;
                            state_reg      <= ST_ONE;
                            occupancy_reg  <= 2'd1;
                        end
                    end
                    default: begin
                        state_reg      <= ST_EMPTY;
                        main_valid_reg <= 1'b0;
                        main_ctrl_reg  <= '0;
                        skid_valid_reg <= 1'b0;
                        skid_ctrl_reg  <= '0;
                        occupancy_reg  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, back-pressure, flush, bubble, async reset, counter saturation.
// A second instance with a 4-bit stall counter covers saturation.
module tb_pipe_stage_skid;

    localparam int DW = 134;
    localparam int CW = 6;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          in_valid_i, flush_i, out_ready_i;
    logic [CW-1:0] in_ctrl_i;
    logic [DW-1:0] in_data_i;
    logic          in_ready_o, out_valid_o;
    logic [CW-1:0] out_ctrl_o;
    logic [DW-1:0] out_data_o;
    logic [1:0]    occupancy_o;
    logic [15:0]   stall_cnt_o;

    logic          s_in_valid, s_out_ready, s_in_ready, s_out_valid;
    logic [5:0]    s_in_ctrl, s_out_ctrl;
    logic [7:0]    s_in_data, s_out_data;
    logic [1:0]    s_occ;
    logic [3:0]    s_stall;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_skid dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
        .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_ctrl_o(out_ctrl_o), .out_data_o(out_data_o),
        .occupancy_o(occupancy_o), .stall_cnt_o(stall_cnt_o)
    );

    pipe_stage_skid #(.DATA_W(8), .CTRL_W(6), .CNT_W(4)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .in_ctrl_i(s_in_ctrl), .in_data_i(s_in_data),
        .flush_i(1'b0),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
        .out_ctrl_o(s_out_ctrl), .out_data_o(s_out_data),
        .occupancy_o(s_occ), .stall_cnt_o(s_stall)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input int d, input logic rdy);
        in_valid_i  = v;
        in_ctrl_i   = c;
        in_data_i   = DW'(d);
        out_ready_i = rdy;
    endtask

    initial begin
        rst_i = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, '0, 0, 1'b0);
        s_in_valid = 1'b0; s_in_ctrl = '0; s_in_data = '0; s_out_ready = 1'b0;

        #12;
        chk("rst_out_valid", 160'(out_valid_o), 160'(0));
        chk("rst_in_ready",  160'(in_ready_o),  160'(1));
        chk("rst_occ",       160'(occupancy_o), 160'(0));
        chk("rst_stall",     160'(stall_cnt_o), 160'(0));
        chk("rst_ctrl",      160'(out_ctrl_o),  160'(0));
        chk("rst_data",      160'(out_data_o),  160'(0));

        #10 rst_i = 1'b1;

        // Streaming: each beat appears one cycle after it is offered.
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, CW'(k), k, 1'b1);
            tick();
            chk($sformatf("stream_data_%0d", k), 160'(out_data_o), 160'(k));
            chk($sformatf("stream_valid_%0d", k), 160'(out_valid_o), 160'(1));
            chk($sformatf("stream_occ_%0d", k), 160'(occupancy_o), 160'(1));
            chk($sformatf("stream_stall_%0d", k), 160'(stall_cnt_o), 160'(0));
        end
        drive(1'b0, '0, 0, 1'b1);
        tick();
        chk("drain_valid", 160'(out_valid_o), 160'(0));
        chk("drain_ctrl",  160'(out_ctrl_o),  160'(0));
        chk("drain_occ",   160'(occupancy_o), 160'(0));

        // Back-pressure: A then B with the sink stalled.
        drive(1'b1, 6'h01, 'hA, 1'b0);
        tick();
        chk("bp_a_occ", 160'(occupancy_o), 160'(1));
        drive(1'b1, 6'h02, 'hB, 1'b0);
        tick();
        chk("bp_full_occ",   160'(occupancy_o), 160'(2));
        chk("bp_full_ready", 160'(in_ready_o),  160'(0));
        chk("bp_full_data",  160'(out_data_o),  160'('hA));
        chk("bp_full_ctrl",  160'(out_ctrl_o),  160'(1));
        chk("bp_stall_1",    160'(stall_cnt_o), 160'(1));
        drive(1'b0, '0, 0, 1'b0);
        tick();
        tick();
        chk("bp_stall_3",    160'(stall_cnt_o), 160'(3));
        chk("bp_hold_data",  160'(out_data_o),  160'('hA));
        out_ready_i = 1'b1;
        tick();
        chk("bp_b_data",  160'(out_data_o),  160'('hB));
        chk("bp_b_ctrl",  160'(out_ctrl_o),  160'(2));
        chk("bp_b_ready", 160'(in_ready_o),  160'(1));
        chk("bp_b_occ",   160'(occupancy_o), 160'(1));
        chk("bp_b_stall", 160'(stall_cnt_o), 160'(3));
        tick();
        chk("bp_empty_valid", 160'(out_valid_o), 160'(0));

        // Flush while FULL with a same-cycle input beat C that must be dropped.
        drive(1'b1, 6'h01, 'h11, 1'b0);
        tick();
        drive(1'b1, 6'h02, 'h22, 1'b0);
        tick();
        chk("fl_full_occ", 160'(occupancy_o), 160'(2));
        chk("fl_stall_4",  160'(stall_cnt_o), 160'(4));
        drive(1'b1, 6'h05, 'h33, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_valid", 160'(out_valid_o), 160'(0));
        chk("fl_ctrl",  160'(out_ctrl_o),  160'(0));
        chk("fl_occ",   160'(occupancy_o), 160'(0));
        chk("fl_ready", 160'(in_ready_o),  160'(1));
        chk("fl_stall", 160'(stall_cnt_o), 160'(5));
        drive(1'b0, '0, 0, 1'b1);
        tick();
        chk("fl_no_c_valid", 160'(out_valid_o), 160'(0));
        chk("fl_no_c_occ",   160'(occupancy_o), 160'(0));

        // Bubble: control visible for one beat, then zero.
        drive(1'b1, 6'h3F, 'h44, 1'b1);
        tick();
        chk("bub_ctrl",  160'(out_ctrl_o),  160'(6'h3F));
        chk("bub_valid", 160'(out_valid_o), 160'(1));
        chk("bub_data",  160'(out_data_o),  160'('h44));
        drive(1'b0, 6'h3F, 0, 1'b1);
        tick();
        chk("bub_ctrl0",  160'(out_ctrl_o),  160'(0));
        chk("bub_valid0", 160'(out_valid_o), 160'(0));

        // Asynchronous reset between edges while FULL.
        drive(1'b1, 6'h01, 'h55, 1'b0);
        tick();
        drive(1'b1, 6'h02, 'h66, 1'b0);
        tick();
        drive(1'b0, '0, 0, 1'b0);
        chk("ar_full_occ", 160'(occupancy_o), 160'(2));
        #2 rst_i = 1'b0;
        #1;
        chk("ar_valid", 160'(out_valid_o), 160'(0));
        chk("ar_ctrl",  160'(out_ctrl_o),  160'(0));
        chk("ar_data",  160'(out_data_o),  160'(0));
        chk("ar_occ",   160'(occupancy_o), 160'(0));
        chk("ar_stall", 160'(stall_cnt_o), 160'(0));
        chk("ar_ready", 160'(in_ready_o),  160'(1));
        #3 rst_i = 1'b1;
        drive(1'b1, 6'h07, 'h77, 1'b1);
        tick();
        chk("ar_first_data",  160'(out_data_o),  160'('h77));
        chk("ar_first_valid", 160'(out_valid_o), 160'(1));
        drive(1'b0, '0, 0, 1'b1);
        tick();

        // Saturation on the 4-bit counter instance.
        s_in_valid = 1'b1; s_in_ctrl = 6'h01; s_in_data = 8'h5A; s_out_ready = 1'b0;
        tick();
        s_in_valid = 1'b0;
        chk("sat_start", 160'(s_stall), 160'(0));
        repeat (10) tick();
        chk("sat_10", 160'(s_stall), 160'(10));
        repeat (10) tick();
        chk("sat_15",   160'(s_stall),     160'(15));
        chk("sat_data", 160'(s_out_data),  160'(8'h5A));
        chk("sat_val",  160'(s_out_valid), 160'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
